// File: rtl/rename_core.sv
// rename_core: register-rename core for a Tomasulo dispatch stage.
// Holds a 32-entry architectural register file, a register status table
// (pending flag + producer tag per register) and a free-tag FIFO.
// Optional macro RENAME_CDB_BYPASS_EN enables same-cycle CDB forwarding
// on the rs/rt read ports (the debug port is never forwarded).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   dispatch_ren/wen/addr      pop a free tag, optionally rename addr to it
//   dispatch_tag/full/empty    FIFO head tag and occupancy flags
//   dispatch_rs*/rt*           combinational source operand reads
//   cdb_tag/valid/data         completion broadcast, also returns the tag
//   debug_addr/debug_data      combinational register file peek
module rename_core #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dispatch_ren,
   input  logic              dispatch_wen,
   input  logic [4:0]        dispatch_addr,
   output logic [TAG_W-1:0]  dispatch_tag,
   output logic              dispatch_full,
   output logic              dispatch_empty,
   input  logic [4:0]        dispatch_rsaddr,
   output logic [TAG_W-1:0]  dispatch_rstag,
   output logic              dispatch_rsvalid,
   output logic [DATA_W-1:0] dispatch_rsdata,
   input  logic [4:0]        dispatch_rtaddr,
   output logic [TAG_W-1:0]  dispatch_rttag,
   output logic              dispatch_rtvalid,
   output logic [DATA_W-1:0] dispatch_rtdata,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic              cdb_valid,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic [4:0]        debug_addr,
   output logic [DATA_W-1:0] debug_data
);

   localparam int unsigned NREG  = 32;
   localparam int unsigned DEPTH = 1 << TAG_W;
   localparam int unsigned CNT_W = TAG_W + 1;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   pend_q, pend_d;
   logic [TAG_W-1:0]  tag_q  [NREG];
   logic [TAG_W-1:0]  tag_d  [NREG];
   logic [TAG_W-1:0]  fifo_q [DEPTH];
   logic [TAG_W-1:0]  fifo_d [DEPTH];
   logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              pop, push, rename;
   logic [NREG-1:0]   wb_en;

   assign dispatch_full  = (count_q == CNT_W'(DEPTH));
   assign dispatch_empty = (count_q == '0);
   assign dispatch_tag   = fifo_q[head_q];
   assign debug_data     = regs_q[debug_addr];

   // A push while full is only possible because the same-cycle pop frees a slot.
   assign pop    = dispatch_ren & ~dispatch_empty;
   assign push   = cdb_valid & (~dispatch_full | pop);
   assign rename = pop & dispatch_wen & (dispatch_addr != 5'd0);

   // One-hot completion vector from the RST tag compare; r0 never matches.
   always_comb begin
      wb_en = '0;
      for (int unsigned r = 1; r < NREG; r++)
         wb_en[r] = cdb_valid & pend_q[r] & (tag_q[r] == cdb_tag);
   end

   // Next state: completion first, then rename so a same-register rename wins the RST.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      tag_d  = tag_q;
      fifo_d = fifo_q;
      for (int unsigned r = 1; r < NREG; r++) begin
         if (wb_en[r]) begin
            regs_d[r] = cdb_data;
            pend_d[r] = 1'b0;
         end
      end
      if (rename) begin
         pend_d[dispatch_addr] = 1'b1;
         tag_d[dispatch_addr]  = fifo_q[head_q];
      end
      if (push)
         fifo_d[tail_q] = cdb_tag;
      head_d  = head_q + TAG_W'(pop);
      tail_d  = tail_q + TAG_W'(push);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
            tag_q[r]  <= '0;
         end
         pend_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            fifo_q[i] <= TAG_W'(i);
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_W'(DEPTH);
      end else begin
         regs_q  <= regs_d;
         pend_q  <= pend_d;
         tag_q   <= tag_d;
         fifo_q  <= fifo_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Source operand read ports, index 0 = rs, 1 = rt.
   logic [4:0]        rd_addr  [2];
   logic [TAG_W-1:0]  rd_tag   [2];
   logic              rd_valid [2];
   logic [DATA_W-1:0] rd_data  [2];

   always_comb begin
      rd_addr[0] = dispatch_rsaddr;
      rd_addr[1] = dispatch_rtaddr;
      for (int unsigned p = 0; p < 2; p++) begin
         rd_tag[p]   = '0;
         rd_valid[p] = 1'b1;
         rd_data[p]  = '0;
         if (rd_addr[p] != 5'd0) begin
            rd_tag[p]   = tag_q[rd_addr[p]];
            rd_valid[p] = ~pend_q[rd_addr[p]];
            rd_data[p]  = regs_q[rd_addr[p]];
`ifdef RENAME_CDB_BYPASS_EN
            if (wb_en[rd_addr[p]]) begin
               rd_valid[p] = 1'b1;
               rd_data[p]  = cdb_data;
            end
`endif
         end
      end
   end

   assign dispatch_rstag   = rd_tag[0];
   assign dispatch_rsvalid = rd_valid[0];
   assign dispatch_rsdata  = rd_data[0];
   assign dispatch_rttag   = rd_tag[1];
   assign dispatch_rtvalid = rd_valid[1];
   assign dispatch_rtdata  = rd_data[1];

endmodule

// File: tb/tb_rename_core.sv
// Scoreboard bench for rename_core: a driver applies directed then random
// stimulus on the falling edge and queues the expected read-side outputs from
// a behavioural model; a monitor pops and compares shortly after each falling edge.
module tb_rename_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        dispatch_ren, dispatch_wen;
   logic [4:0]  dispatch_addr, dispatch_rsaddr, dispatch_rtaddr, debug_addr;
   logic [5:0]  dispatch_tag, dispatch_rstag, dispatch_rttag, cdb_tag;
   logic        dispatch_full, dispatch_empty, dispatch_rsvalid, dispatch_rtvalid, cdb_valid;
   logic [31:0] dispatch_rsdata, dispatch_rtdata, cdb_data, debug_data;

   rename_core dut (
      .clk(clk), .reset(reset),
      .dispatch_ren(dispatch_ren), .dispatch_wen(dispatch_wen), .dispatch_addr(dispatch_addr),
      .dispatch_tag(dispatch_tag), .dispatch_full(dispatch_full), .dispatch_empty(dispatch_empty),
      .dispatch_rsaddr(dispatch_rsaddr), .dispatch_rstag(dispatch_rstag),
      .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rsdata(dispatch_rsdata),
      .dispatch_rtaddr(dispatch_rtaddr), .dispatch_rttag(dispatch_rttag),
      .dispatch_rtvalid(dispatch_rtvalid), .dispatch_rtdata(dispatch_rtdata),
      .cdb_tag(cdb_tag), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
      .debug_addr(debug_addr), .debug_data(debug_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          tag_known;
      logic [5:0]  head;
      logic        full, empty;
      logic [5:0]  rs_tag, rt_tag;
      logic        rs_valid, rt_valid;
      logic [31:0] rs_data, rt_data, dbg;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   bit   done = 1'b0;

   // Behavioural model: arrays for registers/RST and a queue of free tags.
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   logic [5:0]  m_tag  [32];
   logic [5:0]  m_free [$];

   task automatic model_reset();
      m_free.delete();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 0; m_pend[i] = 0; m_tag[i] = 0;
      end
      for (int i = 0; i < 64; i++) m_free.push_back(6'(i));
   endtask

   task automatic model_read(input logic [4:0] a, output logic [5:0] t,
                             output logic v, output logic [31:0] d);
      t = m_tag[a]; v = !m_pend[a]; d = m_regs[a];
`ifdef RENAME_CDB_BYPASS_EN
      if (cdb_valid && m_pend[a] && m_tag[a] == cdb_tag) begin
         v = 1'b1; d = cdb_data;
      end
`endif
   endtask

   task automatic step(input logic ren, input logic wen, input logic [4:0] addr,
                       input logic [4:0] rs, input logic [4:0] rt, input logic cv,
                       input logic [5:0] ctag, input logic [31:0] cdata, input logic [4:0] dbg);
      exp_t e;
      bit pop, push;
      logic [5:0] ptag;
      @(negedge clk);
      cyc++;
      dispatch_ren = ren; dispatch_wen = wen; dispatch_addr = addr;
      dispatch_rsaddr = rs; dispatch_rtaddr = rt;
      cdb_valid = cv; cdb_tag = ctag; cdb_data = cdata; debug_addr = dbg;
      e.tag_known = (m_free.size() > 0);
      e.head  = e.tag_known ? m_free[0] : 6'd0;
      e.full  = (m_free.size() == 64);
      e.empty = (m_free.size() == 0);
      model_read(rs, e.rs_tag, e.rs_valid, e.rs_data);
      model_read(rt, e.rt_tag, e.rt_valid, e.rt_data);
      e.dbg = m_regs[dbg];
      exp_q.push_back(e);
      // Advance the model to the state after the coming rising edge.
      pop  = ren && (m_free.size() > 0);
      push = cv && (m_free.size() < 64 || pop);
      ptag = pop ? m_free[0] : 6'd0;
      if (cv)
         for (int r = 1; r < 32; r++)
            if (m_pend[r] && m_tag[r] == ctag) begin
               m_regs[r] = cdata; m_pend[r] = 0;
            end
      if (pop && wen && addr != 0) begin
         m_pend[addr] = 1; m_tag[addr] = ptag;
      end
      if (pop) void'(m_free.pop_front());
      if (push) m_free.push_back(ctag);
   endtask

   task automatic idle(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
      step(0, 0, 0, rs, rt, 0, 0, 0, dbg);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; dispatch_ren = 0; dispatch_wen = 0; cdb_valid = 0;
      @(negedge clk);
      reset = 0;
      model_reset();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
   endtask

   // Monitor: compares the DUT against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.tag_known) chk("dispatch_tag", 32'(dispatch_tag), 32'(e.head));
            chk("full", 32'(dispatch_full), 32'(e.full));
            chk("empty", 32'(dispatch_empty), 32'(e.empty));
            chk("rstag", 32'(dispatch_rstag), 32'(e.rs_tag));
            chk("rsvalid", 32'(dispatch_rsvalid), 32'(e.rs_valid));
            chk("rsdata", dispatch_rsdata, e.rs_data);
            chk("rttag", 32'(dispatch_rttag), 32'(e.rt_tag));
            chk("rtvalid", 32'(dispatch_rtvalid), 32'(e.rt_valid));
            chk("rtdata", dispatch_rtdata, e.rt_data);
            chk("debug_data", debug_data, e.dbg);
         end
      end
   end

   // Driver.
   initial begin
      logic [4:0] r;
      logic [5:0] ct;
      reset = 1; dispatch_ren = 0; dispatch_wen = 0; dispatch_addr = 0;
      dispatch_rsaddr = 0; dispatch_rtaddr = 0; cdb_valid = 0; cdb_tag = 0;
      cdb_data = 0; debug_addr = 0;
      do_reset();

      // Reset state, then rename r5 three times and complete its last tag.
      idle(1, 31, 31);
      repeat (3) step(1, 1, 5, 5, 0, 0, 0, 0, 5);
      idle(5, 1, 5);
      step(0, 0, 0, 5, 0, 1, 2, 32'hDEADBEEF, 5);
      idle(5, 5, 5);

      // Drain the FIFO, pop while empty, then return tag 7.
      repeat (66) step(1, 0, 0, 5, 1, 0, 0, 0, 5);
      step(1, 1, 9, 9, 0, 0, 0, 0, 9);
      step(0, 0, 0, 9, 0, 1, 7, 32'h1, 9);
      idle(9, 5, 5);

      // Same-cycle rename of r3 and completion of its old tag 4.
      do_reset();
      repeat (4) step(1, 1, 1, 1, 3, 0, 0, 0, 1);
      step(1, 1, 3, 3, 1, 0, 0, 0, 3);
      repeat (4) step(1, 1, 1, 3, 1, 0, 0, 0, 3);
      step(1, 1, 3, 3, 0, 1, 4, 32'h55, 3);
      idle(3, 1, 3);

      // Renaming r0 consumes a tag but leaves r0 reading zero.
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(0, 0, 0);

      // Pending r6 with tag 1 completing while being read.
      do_reset();
      step(1, 1, 2, 6, 2, 0, 0, 0, 6);
      step(1, 1, 6, 6, 2, 0, 0, 0, 6);
      step(0, 0, 0, 6, 2, 1, 1, 32'h12, 6);
      idle(6, 2, 6);

      // Random traffic; completions mostly target a live producer tag.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         r  = 5'($urandom_range(1, 31));
         ct = m_pend[r] && ($urandom_range(0, 3) != 0) ? m_tag[r] : 6'($urandom_range(0, 63));
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              5'($urandom_range(0, 31)), ($urandom_range(0, 1) != 0) ? r : 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) == 0), ct,
              $urandom, 5'($urandom_range(0, 31)));
      end
      idle(0, 0, 0);
      done = 1;
   end

   // Finish once the scoreboard drains, with a bounded wait.
   initial begin
      int budget;
      budget = 0;
      wait (done);
      while (exp_q.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
         n_total++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rename_core.md
Name: rename_core

Overview:
- Register-rename core of the Tomasulo dispatch stage. Combines three parts:
  - a 32x32 architectural register file;
  - a register status table (RST) that maps each register to its pending producer tag;
  - a tag FIFO that hands out free 6-bit tags.
- Dispatch uses it to read source operands/tags and to rename a destination register.
- The CDB uses it to complete results and return tags to the free pool.

Parameters:
- DATA_W, 32: register/CDB data width.
- TAG_W, 6: tag width; tag FIFO depth = 2**TAG_W (64).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- dispatch_ren  in  1  allocate (pop) the head tag.
- dispatch_wen  in  1  with a successful allocation, rename dispatch_addr to the allocated tag.
- dispatch_addr  in  5  destination register to rename.
- dispatch_tag  out  TAG_W  current FIFO head (the tag the next pop returns).
- dispatch_full  out  1  tag FIFO full (all tags free).
- dispatch_empty  out  1  tag FIFO empty (no free tag).
- dispatch_rsaddr  in  5  source-s register address.
- dispatch_rstag  out  TAG_W  RST tag for rs.
- dispatch_rsvalid  out  1  1 = rs data is valid (no pending producer).
- dispatch_rsdata  out  DATA_W  register file value for rs.
- dispatch_rtaddr, dispatch_rttag, dispatch_rtvalid, dispatch_rtdata: identical to the rs group, for rt.
- cdb_tag  in  TAG_W  completing tag.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_data  in  DATA_W  completing result.
- debug_addr  in  5  debug read address.
- debug_data  out  DATA_W  register file value at debug_addr (combinational).

Behaviour:

Reset (synchronous, high):
- All 32 registers = 0.
- All RST entries = not pending, tag 0.
- FIFO holds tags 0,1,...,63 in order; head = 0, count = 64.
- Outputs after reset: dispatch_tag=0, dispatch_full=1, dispatch_empty=0; all read outputs reflect zeroed state (valid=1, data=0, tag=0).

Reads:
- All read ports are combinational and reflect state before the current edge.
- A same-cycle rename of the same register does not affect the reads (rd==rs reads the old mapping).
- Register 0 always reads data 0, valid 1, tag 0.

Tag FIFO:
- pop = dispatch_ren & ~empty. Returns dispatch_tag and advances the head.
- push = cdb_valid. Writes cdb_tag at the tail.
  - Push while full is ignored.
  - Push and pop in the same cycle when full are both performed; count is unchanged.
  - When empty, pop is ignored and push is accepted.
- Head/tail pointers wrap modulo 64. full = (count==64); empty = (count==0).

Rename:
- Fires when pop & dispatch_wen & dispatch_addr!=0.
- Sets RST[dispatch_addr] = {pending=1, tag=dispatch_tag}.
- Rename to register 0 is ignored; the tag is still popped.

CDB completion (cdb_valid):
- For every register r != 0 with RST[r] pending and tag == cdb_tag:
  - reg[r] <= cdb_data;
  - RST[r] pending <= 0.
- Use a one-hot write-enable vector built from the RST compare; multiple matching registers are all written.

Simultaneous rename and completion on the same register:
- The register file is written with cdb_data.
- The RST takes the new dispatch mapping (pending=1, new tag).

Validity:
- Without bypass, rsvalid/rtvalid = ~pending.

Optional Feature:
- Macro RENAME_CDB_BYPASS_EN.
- Defined: a read port whose entry is pending with tag == cdb_tag while cdb_valid=1 returns valid=1 and data=cdb_data in that same cycle (same-cycle forwarding). The debug port is not bypassed.
- Undefined: such reads return valid=0 and the stale register value; the result becomes visible the next cycle.

Test Plan:
- Reset, then idle -> dispatch_tag=0, full=1, empty=0; reads of r1/r31 give data 0, valid 1.
- Pop with wen, addr=5, three cycles in a row -> r5 tag=2 pending (valid=0); dispatch_tag=3; full=0.
- Then CDB valid, tag=2, data=0xDEADBEEF -> next cycle r5 valid=1, data=0xDEADBEEF; debug_addr=5 reads 0xDEADBEEF; tag 2 is at the FIFO tail.
- Pop 64 tags without CDB -> empty=1; a further pop leaves state unchanged. CDB returns tag 7 -> empty=0, dispatch_tag=7.
- Same cycle: rename r3 (new tag 9) while CDB completes r3's old tag 4 with 0x55 -> r3 data=0x55, pending=1, tag=9.
- Rename r0 -> r0 still reads 0, valid 1; tag consumed. Bypass case (RENAME_CDB_BYPASS_EN defined): pending r6 tag 1, CDB tag 1 data 0x12 -> rs read of r6 gives valid 1, data 0x12 in the same cycle.
